// File: rtl/aes256_axil_pkg.sv
// Shared definitions for the AES AXI4-Lite register block: register map,
// sequencer state encoding, STATUS bit positions and a byte-strobe helper.
package aes256_axil_pkg;

    // Byte offsets of the register map
    localparam int unsigned OFS_KEY0   = 32'h00;
    localparam int unsigned OFS_PT0    = 32'h20;
    localparam int unsigned OFS_CTRL   = 32'h30;
    localparam int unsigned OFS_STATUS = 32'h34;
    localparam int unsigned OFS_IRQ_EN = 32'h38;
    localparam int unsigned OFS_CT0    = 32'h40;

    // Same map as 32-bit word indices, which is what the decoder compares against
    localparam int unsigned KEY_BASE_W = OFS_KEY0 >> 2;
    localparam int unsigned PT_BASE_W  = OFS_PT0 >> 2;
    localparam int unsigned CTRL_W     = OFS_CTRL >> 2;
    localparam int unsigned STATUS_W   = OFS_STATUS >> 2;
    localparam int unsigned IRQ_EN_W   = OFS_IRQ_EN >> 2;
    localparam int unsigned CT_BASE_W  = OFS_CT0 >> 2;

    localparam int unsigned BLOCK_WORDS = 4;

    // STATUS bit positions
    localparam int unsigned STATUS_BUSY = 0;
    localparam int unsigned STATUS_DONE = 1;
    localparam int unsigned STATUS_ERR  = 2;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } core_state_e;

    // Merge new write data into an existing word under a byte strobe
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/aes256_axil_regs.sv
// AXI4-Lite register front end for an AES block core: key/plaintext/ciphertext
// registers, a start/busy/done sequencer and a stream-style core handshake.
// Optional level interrupt enabled by defining AES256_AXIL_IRQ_EN.
module aes256_axil_regs
    import aes256_axil_pkg::*;
#(
    parameter int unsigned KEY_WORDS          = 8,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 7
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,

    output logic [32*KEY_WORDS-1:0]       core_key,
    output logic [127:0]                  core_pt,
    output logic                          core_in_valid,
    input  logic                          core_in_ready,
    input  logic [127:0]                  core_ct,
    input  logic                          core_out_valid,
    output logic                          core_out_ready,

    output logic                          irq
);

    logic [31:0] key_q [KEY_WORDS];
    logic [31:0] pt_q  [BLOCK_WORDS];
    logic [31:0] ct_q  [BLOCK_WORDS];

    core_state_e state_q, state_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        busy;
    logic        out_hs;

    logic        bvalid_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;

    logic        wr_en;
    logic        rd_en;
    logic [31:0] wr_idx;
    logic [31:0] rd_idx;
    logic [31:0] rd_val;
    logic        key_hit;
    logic        pt_hit;
    logic        start_req;
    logic        busy_violation;

    logic        unused_addr_lsbs;
    assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Both channels are accepted together; one outstanding response at a time
    assign wr_en  = ARESETN & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
    assign rd_en  = ARESETN & S_AXI_ARVALID & ~rvalid_q;
    assign wr_idx = 32'(S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]);
    assign rd_idx = 32'(S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]);

    assign S_AXI_AWREADY = wr_en;
    assign S_AXI_WREADY  = wr_en;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = rd_en;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;

    assign busy = (state_q != StIdle);

    for (genvar k = 0; k < KEY_WORDS; k++) begin : g_core_key
        assign core_key[32*k +: 32] = key_q[k];
    end
    assign core_pt = {pt_q[3], pt_q[2], pt_q[1], pt_q[0]};

    // Write-address decode for the registers that are locked while busy
    always_comb begin
        key_hit = 1'b0;
        pt_hit  = 1'b0;
        for (int unsigned k = 0; k < KEY_WORDS; k++) begin
            if (wr_idx == KEY_BASE_W + k) key_hit = 1'b1;
        end
        for (int unsigned i = 0; i < BLOCK_WORDS; i++) begin
            if (wr_idx == PT_BASE_W + i) pt_hit = 1'b1;
        end
        start_req      = wr_en && (wr_idx == CTRL_W) && S_AXI_WSTRB[0] && S_AXI_WDATA[0];
        busy_violation = wr_en && busy && (key_hit || pt_hit || start_req);
    end

    // AXI response channel state: BVALID/RVALID held until accepted
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (wr_en) begin
                bvalid_q <= 1'b1;
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
            if (rd_en) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_val;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // Sequencer state register
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencer next state and core handshake outputs
    always_comb begin
        state_d        = state_q;
        core_in_valid  = 1'b0;
        core_out_ready = 1'b0;
        out_hs         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_req) state_d = StIssue;
            end
            StIssue: begin
                core_in_valid = 1'b1;
                if (core_in_ready) state_d = StWait;
            end
            StWait: begin
                core_out_ready = 1'b1;
                if (core_out_valid) begin
                    out_hs  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Sticky STATUS flags; completion wins over a simultaneous clear of done
    always_comb begin
        done_d = done_q;
        err_d  = err_q;
        if (wr_en && (wr_idx == STATUS_W) && S_AXI_WSTRB[0]) begin
            if (S_AXI_WDATA[STATUS_DONE]) done_d = 1'b0;
            if (S_AXI_WDATA[STATUS_ERR])  err_d  = 1'b0;
        end
        if (busy_violation) err_d  = 1'b1;
        if (out_hs)         done_d = 1'b1;
    end

    // Register file: key/plaintext writable only when idle, CT captured on completion
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            for (int unsigned k = 0; k < KEY_WORDS; k++) key_q[k] <= '0;
            for (int unsigned i = 0; i < BLOCK_WORDS; i++) begin
                pt_q[i] <= '0;
                ct_q[i] <= '0;
            end
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= done_d;
            err_q  <= err_d;
            if (wr_en && !busy) begin
                for (int unsigned k = 0; k < KEY_WORDS; k++) begin
                    if (wr_idx == KEY_BASE_W + k) begin
                        key_q[k] <= apply_wstrb(key_q[k], S_AXI_WDATA, S_AXI_WSTRB);
                    end
                end
                for (int unsigned i = 0; i < BLOCK_WORDS; i++) begin
                    if (wr_idx == PT_BASE_W + i) begin
                        pt_q[i] <= apply_wstrb(pt_q[i], S_AXI_WDATA, S_AXI_WSTRB);
                    end
                end
            end
            if (out_hs) begin
                for (int unsigned i = 0; i < BLOCK_WORDS; i++) begin
                    ct_q[i] <= core_ct[32*i +: 32];
                end
            end
        end
    end

`ifdef AES256_AXIL_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q;

    // Interrupt enable next state
    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_en && (wr_idx == IRQ_EN_W) && S_AXI_WSTRB[0]) irq_en_d = S_AXI_WDATA[0];
    end

    // Registered level interrupt tracking done in the same edge
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= done_d & irq_en_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // Read data mux; unmapped words read as zero
    always_comb begin
        rd_val = '0;
        for (int unsigned k = 0; k < KEY_WORDS; k++) begin
            if (rd_idx == KEY_BASE_W + k) rd_val = key_q[k];
        end
        for (int unsigned i = 0; i < BLOCK_WORDS; i++) begin
            if (rd_idx == PT_BASE_W + i) rd_val = pt_q[i];
            if (rd_idx == CT_BASE_W + i) rd_val = ct_q[i];
        end
        if (rd_idx == STATUS_W) begin
            rd_val[STATUS_BUSY] = busy;
            rd_val[STATUS_DONE] = done_q;
            rd_val[STATUS_ERR]  = err_q;
        end
`ifdef AES256_AXIL_IRQ_EN
        if (rd_idx == IRQ_EN_W) rd_val[0] = irq_en_q;
`endif
    end

endmodule
